// File: rtl/mem_stage_pkg.sv
// Shared opcode constants, memory-op decode and the EX/MEM register layout
// for the MEM stage.
package mem_stage_pkg;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_ROP = 6'h00;

  localparam int unsigned MEM_BYTE_LANES = 4;

  typedef enum logic [2:0] {
    MOP_NONE,
    MOP_LW,
    MOP_SW,
    MOP_LB,
    MOP_SB
  } mop_e;

  typedef struct packed {
    logic        valid;
    mop_e        mop;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  wreg;
    logic        regwrite;
  } exmem_t;

  function automatic mop_e decode_op(input logic [5:0] op);
    case (op)
      OP_LW:   decode_op = MOP_LW;
      OP_SW:   decode_op = MOP_SW;
      OP_LB:   decode_op = MOP_LB;
      OP_SB:   decode_op = MOP_SB;
      default: decode_op = MOP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX-side inputs and forwarding/writeback outputs of the MEM stage.
interface mem_stage_if;
  logic        ex_valid;
  logic [5:0]  ex_op;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wreg;
  logic        ex_regwrite;
  logic        mem_stall;
  logic        mem_flush;
  logic        fwd_valid;
  logic [4:0]  fwd_wreg;
  logic [31:0] fwd_data;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_wreg;
  logic [31:0] wb_wdata;
  logic        addr_err;

  modport master (
    output ex_valid, ex_op, ex_alu_result, ex_store_data, ex_wreg, ex_regwrite,
           mem_stall, mem_flush,
    input  fwd_valid, fwd_wreg, fwd_data,
           wb_valid, wb_regwrite, wb_wreg, wb_wdata, addr_err
  );

  modport slave (
    input  ex_valid, ex_op, ex_alu_result, ex_store_data, ex_wreg, ex_regwrite,
           mem_stall, mem_flush,
    output fwd_valid, fwd_wreg, fwd_data,
           wb_valid, wb_regwrite, wb_wreg, wb_wdata, addr_err
  );
endinterface

// File: rtl/mem_stage_dm_ram.sv
// Data memory: byte-write-enabled word array, combinational read,
// synchronous write and synchronous active-low clear of every word.
module dm_ram
  import mem_stage_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024,
  localparam int unsigned AW = $clog2(DM_WORDS)
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic [MEM_BYTE_LANES-1:0] we,
  input  logic [AW-1:0]             addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata
);

  logic [31:0] mem [DM_WORDS];

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < MEM_BYTE_LANES; k++)
        if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data memory access with byte-lane
// steering, MEM/WB register, writeback bus and MEM-stage forwarding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic      clk,
  input  logic      reset_n,
  mem_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(DM_WORDS);

  exmem_t                    exm;
  logic [AW-1:0]             idx;
  logic [1:0]                lane;
  logic                      misal;
  logic [MEM_BYTE_LANES-1:0] we;
  logic [31:0]               wdata;
  logic [31:0]               rdata;
  logic [7:0]                lbyte;
  logic [31:0]               result;

  logic        wb_valid_q;
  logic        wb_regwrite_q;
  logic [4:0]  wb_wreg_q;
  logic [31:0] wb_wdata_q;
  logic        addr_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exm <= '0;
    end else if (!bus.mem_stall) begin
      exm.valid    <= bus.ex_valid & ~bus.mem_flush;
      exm.mop      <= decode_op(bus.ex_op);
      exm.alu      <= bus.ex_alu_result;
      exm.sdata    <= bus.ex_store_data;
      exm.wreg     <= bus.ex_wreg;
      exm.regwrite <= bus.ex_regwrite;
    end
  end

  // Stores commit on the edge that moves them into MEM/WB, so a stalled
  // store keeps its write enables low until the stall releases.
  always_comb begin
    lane  = exm.alu[1:0];
    idx   = exm.alu[AW+1:2];
    misal = ((exm.mop == MOP_LW) || (exm.mop == MOP_SW)) && (lane != 2'd0);
    we    = '0;
    wdata = exm.sdata;
    if (exm.valid && !bus.mem_stall && !misal) begin
      case (exm.mop)
        MOP_SW:  we = '1;
        MOP_SB: begin
          we    = MEM_BYTE_LANES'(1) << lane;
          wdata = {MEM_BYTE_LANES{exm.sdata[7:0]}};
        end
        default: we = '0;
      endcase
    end
    lbyte = rdata[8*lane +: 8];
    case (exm.mop)
      MOP_LW:  result = rdata;
      MOP_LB:  result = {{24{lbyte[7]}}, lbyte};
      default: result = exm.alu;
    endcase
  end

  dm_ram #(.DM_WORDS(DM_WORDS)) u_dm (
    .clk     (clk),
    .clear_n (reset_n),
    .we      (we),
    .addr    (idx),
    .wdata   (wdata),
    .rdata   (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_wreg_q     <= '0;
      wb_wdata_q    <= '0;
      addr_err_q    <= 1'b0;
    end else if (!bus.mem_stall) begin
      wb_valid_q    <= exm.valid;
      wb_regwrite_q <= exm.valid & exm.regwrite & (exm.wreg != 5'd0) & ~misal;
      wb_wreg_q     <= exm.wreg;
      wb_wdata_q    <= result;
      addr_err_q    <= exm.valid & misal;
    end
  end

  assign bus.fwd_valid   = exm.valid & exm.regwrite & (exm.wreg != 5'd0) &
                           (exm.mop != MOP_LW) & (exm.mop != MOP_LB);
  assign bus.fwd_wreg    = exm.wreg;
  assign bus.fwd_data    = exm.alu;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.wb_wreg     = wb_wreg_q;
  assign bus.wb_wdata    = wb_wdata_q;
  assign bus.addr_err    = addr_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It consumes the EX-stage ALU result as either a data address or a pass-through value.
- Owns the EX/MEM pipeline register, the byte-addressable data memory (lw/sw/lb/sb) and the MEM/WB register.
- Drives the writeback bus and the MEM-stage forwarding path back to EX.

Parameters:
- DM_WORDS, 1024, data memory depth in 32-bit words (power of 2); index = addr[log2(DM_WORDS)+1:2].

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  EX holds a real instruction.
- ex_op  in  6  opcode (`lw, `sw, `lb, `sb, others pass-through), constants from head.v.
- ex_alu_result  in  32  ALU result: address for memory ops, else the writeback value.
- ex_store_data  in  32  rt value for sw/sb.
- ex_wreg  in  5  destination register.
- ex_regwrite  in  1  instruction writes a register.
- mem_stall  in  1  freeze both pipeline registers.
- mem_flush  in  1  load a bubble into EX/MEM.
- fwd_valid  out  1  MEM-stage result forwardable.
- fwd_wreg  out  5  forwarded destination.
- fwd_data  out  32  forwarded value (EX/MEM ALU result).
- wb_valid  out  1  WB holds a real instruction.
- wb_regwrite  out  1  commit wb_wdata to the register file.
- wb_wreg  out  5  writeback destination.
- wb_wdata  out  32  writeback data.
- addr_err  out  1  misaligned lw/sw; aligned with wb_valid.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-low reset, reset_n, sampled on the clk rising edge.
- Reset effect: while reset_n=0 at an edge, both registers clear (valid=0, regwrite=0, wreg=0, data=0). Every data memory word clears to 0. Outputs after reset: all 0.
- Reset mid-operation discards in-flight instructions. A store sitting in EX/MEM at the reset edge does not commit.
- Pipeline and latency: EX inputs are captured into EX/MEM at edge E. The memory access is combinational read during cycle E..E+1. The store commits at edge E+1, when MEM/WB captures, so wb_* is visible after E+1. Latency = 2 edges from EX inputs to wb_*.
- Back-to-back sw then lw to the same word: the lw reads the new data, because the store commits at the same edge the lw enters MEM.
- Memory ops:
  - Byte lanes are little-endian: lane k = bits [8k+7:8k], with k = addr[1:0].
  - lw: wb_wdata = word.
  - lb: wb_wdata = sign-extended lane k.
  - sw: writes the full word.
  - sb: writes lane k only; other lanes are unchanged.
  - Address bits above the index are ignored, so addresses wrap modulo DM_WORDS*4.
- Misalignment: lw/sw with addr[1:0]≠0 performs no write and forces wb_regwrite=0. addr_err=1 for that instruction's one WB cycle. lb/sb are never misaligned.
- Pass-through (non-memory op): wb_wdata = ALU result.
- Register-0 suppression: wb_regwrite = valid & regwrite & (wreg≠0) & ~addr_err.
- Forwarding: fwd_valid = EX/MEM valid & regwrite & wreg≠0 & op not in {lw, lb}. Loads are never forwarded from MEM; EX hazard logic stalls instead. fwd_wreg and fwd_data come from the EX/MEM register.
- mem_stall=1: both registers hold their values, and no memory write occurs at that edge. The store commits on the first unstalled edge.
- mem_flush=1 (stall=0): EX/MEM valid ← 0. MEM/WB still advances normally.
- Simultaneous stall and flush: stall wins.
- ex_valid=0: treated as a bubble, so no write and no regwrite.

Decomposition:
- Opcode constants (`lw, `sw, `lb, `sb, `ROp) stay in the shared head.v. Add a `MEM_BYTE_LANES constant there.
- One sub-module, dm_ram: DM_WORDS×32 array, 4-bit byte write-enable, combinational read, synchronous write and synchronous active-low clear.
- Lane steering and sign extension stay in mem_stage.

Test Plan:
- Store/load word: sw 0x12345678 to addr 0x10, then lw from 0x10 on the next cycle → wb_wdata=0x12345678 and wb_regwrite=1, two edges after the lw enters EX.
- Byte lanes and sign extension: sb 0xAB to 0x21 over a zeroed word, then lw 0x20 → 0x0000AB00. lb 0x21 → 0xFFFFFFAB. lb 0x20 → 0x00000000.
- Misaligned access: sw to 0x13 → memory unchanged and addr_err=1 for one cycle. lw from 0x22 → wb_regwrite=0, addr_err=1.
- Stall on a store: mem_stall high for 3 cycles with sw in EX/MEM → no write, wb_* held. Write occurs on the release edge, verified by a following lw.
- Flush and forwarding:
  - mem_flush on an addu (wreg=5, result 7) → no writeback.
  - Unflushed addu → fwd_valid=1, fwd_wreg=5, fwd_data=7 while in MEM.
  - lw → fwd_valid=0.
- Reset mid-run: reset_n low for one edge with sw pending → all outputs 0, and a subsequent lw of that address returns 0.
